// File: rtl/fetch_prefetcher.sv
// fetch_prefetcher: credit-based sequential instruction prefetch into a FIFO; FETCH_PERF_CNT_EN adds perf counters
module fetch_prefetcher #(
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [63:0] BOOT_ADDR       = 64'h0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic        redirect_i,
    input  logic [63:0] redirect_addr_i,
    output logic [63:0] instr_if_address_o,
    output logic        instr_if_data_req_o,
    input  logic        instr_if_data_gnt_i,
    input  logic        instr_if_data_rvalid_i,
    input  logic [63:0] instr_if_data_rdata_i,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] perf_stall_cnt_o,
    output logic [31:0] perf_discard_cnt_o,
`endif
    output logic        fetch_valid_o,
    output logic [63:0] fetch_data_o,
    output logic [63:0] fetch_addr_o,
    input  logic        fetch_ready_i
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + MAX_OUTSTANDING + 1);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] REQ  = 1'b1;

    logic [0:0]                  r_state;
    logic [63:0]                 r_addr, r_pend_addr, r_rsp_addr;
    logic                        r_stale;
    logic [CW-1:0]               r_out, r_disc, r_cnt;
    logic [PW-1:0]               r_wptr, r_rptr;
    logic [FIFO_DEPTH-1:0][63:0] r_data, r_faddr;

    logic          w_gnt, w_push, w_pop, w_drop, w_credit;
    logic [CW-1:0] w_out_n, w_disc_n, w_cnt_n;
    logic [63:0]   w_redir_addr, w_addr_n;
    logic [0:0]    w_state_n;

    assign instr_if_data_req_o = r_state == REQ;
    assign instr_if_address_o  = r_addr;
    assign fetch_valid_o       = r_cnt != '0;
    assign fetch_data_o        = r_data[r_rptr];
    assign fetch_addr_o        = r_faddr[r_rptr];

    always_comb begin
        w_redir_addr = {redirect_addr_i[63:3], 3'b000};
        w_gnt        = instr_if_data_req_o & instr_if_data_gnt_i;
        w_drop       = instr_if_data_rvalid_i & (redirect_i | (r_disc != '0));
        w_push       = instr_if_data_rvalid_i & ~w_drop;
        w_pop        = fetch_valid_o & fetch_ready_i & ~redirect_i;
        w_out_n      = r_out + CW'(w_gnt) - CW'(instr_if_data_rvalid_i);
        // a request granted after a redirect (stale) is already owed to the discard count
        w_disc_n     = redirect_i ? w_out_n
                     : r_disc - CW'(instr_if_data_rvalid_i && r_disc != '0) + CW'(w_gnt & r_stale);
        w_cnt_n      = redirect_i ? '0 : r_cnt + CW'(w_push) - CW'(w_pop);
        w_credit     = (w_cnt_n + w_out_n - w_disc_n < CW'(FIFO_DEPTH)) && (w_out_n < CW'(MAX_OUTSTANDING));
        w_state_n    = ((r_state == REQ && !w_gnt) || (en_i && w_credit)) ? REQ : IDLE;
        w_addr_n     = w_gnt ? (redirect_i ? w_redir_addr : r_stale ? r_pend_addr : r_addr + 64'd8)
                     : (redirect_i && r_state == IDLE) ? w_redir_addr : r_addr;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_addr      <= {BOOT_ADDR[63:3], 3'b000};
            r_pend_addr <= '0;
            r_rsp_addr  <= {BOOT_ADDR[63:3], 3'b000};
            r_stale     <= 1'b0;
            r_out       <= '0;
            r_disc      <= '0;
            r_cnt       <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_data      <= '0;
            r_faddr     <= '0;
        end else begin
            r_state     <= w_state_n;
            r_addr      <= w_addr_n;
            r_pend_addr <= redirect_i ? w_redir_addr : r_pend_addr;
            r_rsp_addr  <= redirect_i ? w_redir_addr : w_push ? r_rsp_addr + 64'd8 : r_rsp_addr;
            r_stale     <= !w_gnt && (r_stale || (redirect_i && instr_if_data_req_o));
            r_out       <= w_out_n;
            r_disc      <= w_disc_n;
            r_cnt       <= w_cnt_n;
            r_wptr      <= redirect_i ? '0 : r_wptr + PW'(w_push);
            r_rptr      <= redirect_i ? '0 : r_rptr + PW'(w_pop);
            if (w_push) begin
                r_data[r_wptr]  <= instr_if_data_rdata_i;
                r_faddr[r_wptr] <= r_rsp_addr;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_stall_cnt, r_discard_cnt;
    assign perf_stall_cnt_o   = r_stall_cnt;
    assign perf_discard_cnt_o = r_discard_cnt;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stall_cnt   <= '0;
            r_discard_cnt <= '0;
        end else begin
            r_stall_cnt   <= r_stall_cnt + 32'(en_i && !instr_if_data_req_o && !redirect_i && r_stall_cnt != '1);
            r_discard_cnt <= r_discard_cnt + 32'(w_drop && r_discard_cnt != '1);
        end
    end
`endif

`ifndef SYNTHESIS
    assert property (@(posedge clk_i) disable iff (!rst_ni) instr_if_data_rvalid_i |-> r_out != '0);
    assert property (@(posedge clk_i) disable iff (!rst_ni) (w_push && !w_pop) |-> r_cnt != CW'(FIFO_DEPTH));
`endif
endmodule

// File: doc/fetch_prefetcher.md
Name: fetch_prefetcher

Overview:
- Instruction prefetch stage sitting directly upstream of the core memory instruction port.
- Issues sequential 64-bit-aligned fetch requests on the req/gnt/rvalid instruction interface and buffers returned words with their addresses in a FIFO for the decoder.
- Handles redirects by flushing buffered data and discarding in-flight responses.
- Uses credit-based issue so the FIFO never overflows.

Parameters:
- FIFO_DEPTH, 4, fetch buffer entries (power of two, >=2)
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered requests (>=1)
- BOOT_ADDR, 64'h0, fetch address after reset (bits [2:0] ignored)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- en_i  in  1  fetch enable; when low, no new request is started
- redirect_i  in  1  restart fetching at redirect_addr_i
- redirect_addr_i  in  64  new fetch address; bits [2:0] forced to 0
- instr_if_address_o  out  64  request address, 8-byte aligned
- instr_if_data_req_o  out  1  request valid
- instr_if_data_gnt_i  in  1  request accepted when req & gnt
- instr_if_data_rvalid_i  in  1  in-order response valid
- instr_if_data_rdata_i  in  64  response data
- fetch_valid_o  out  1  FIFO head valid
- fetch_data_o  out  64  FIFO head data
- fetch_addr_o  out  64  FIFO head address
- fetch_ready_i  in  1  consumer pops head when valid & ready

Behaviour:
- Reset is asynchronous, active-low on rst_ni; clock is clk_i.
- Reset values:
  - req_o = 0; address_o = BOOT_ADDR & ~7.
  - fetch_valid_o = 0; fetch_data_o = 0; fetch_addr_o = 0.
  - outstanding, discard counter, FIFO pointers and FIFO occupancy all 0.
- FSM states:
  - IDLE: req_o = 0.
  - REQ: req_o = 1, waiting for gnt.
  - IDLE -> REQ when en_i and credit is available.
  - REQ -> IDLE on gnt when en_i = 0 or no credit remains.
  - REQ stays in REQ on gnt with credit; address_o += 8.
- Credit: new request only when (occupancy + outstanding_live) < FIFO_DEPTH and outstanding < MAX_OUTSTANDING.
  - outstanding_live = outstanding - discard_cnt.
- Request stability:
  - Once req_o is high it is never dropped and address_o never changes until gnt, including across en_i low and redirect_i.
  - After gnt, address_o advances by 8, wrapping mod 2^64.
- outstanding counter:
  - +1 on req & gnt; -1 on rvalid; both in one cycle leaves it unchanged.
  - rvalid with outstanding = 0 is an assertion error.
- Response handling:
  - If discard_cnt > 0: drop the word, discard_cnt -= 1.
  - Otherwise push {rsp_addr_q, rdata} and increment rsp_addr_q by 8.
  - Pushed entry is visible on fetch_valid_o in the cycle after rvalid.
- FIFO:
  - Registered head; simultaneous push and pop allowed at any occupancy.
  - Pop when empty is ignored.
  - Overflow is impossible by credit; it is covered by an assertion.
- redirect_i (single cycle, highest priority):
  - FIFO cleared: fetch_valid_o = 0 next cycle; a same-cycle pop is ignored.
  - A response arriving in the redirect cycle is dropped.
  - discard_cnt <= outstanding after this cycle's gnt/rvalid updates, including a request granted this cycle.
  - If req_o is pending ungranted, it completes with its old address; on its gnt discard_cnt also increments. A stale flag marks it.
  - The next new request and rsp_addr_q use redirect_addr_i & ~7.
  - Back-to-back redirects: the last one wins; all earlier in-flight words are discarded.
- en_i low: in-flight responses are still accepted into the FIFO.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, adds output ports:
  - perf_stall_cnt_o (32): counts cycles with en_i=1, req_o=0 and no redirect.
  - perf_discard_cnt_o (32): counts dropped responses.
  - Both saturate at 2^32-1 and reset to 0.
- When undefined, these ports and counters do not exist; other behaviour is identical.

Test Plan:
- Reset, BOOT_ADDR=0x1000, en_i=1, gnt=req, rvalid one cycle after gnt, ready=1 -> addresses 0x1000, 0x1008, 0x1010...; fetch_addr_o and fetch_data_o match memory in order; first fetch_valid_o two cycles after first req.
- ready_i=0 with FIFO_DEPTH=4 -> exactly 4 entries buffered and req_o drops; ready_i=1 -> requests resume with no lost or duplicated addresses.
- redirect_i to 0x2003 with 2 outstanding -> next 2 rvalids dropped; first delivered entry has address 0x2000; FIFO empty the cycle after redirect.
- gnt held low 3 cycles with redirect to 0x4000 during the stall -> address_o stays at the old value until gnt; that response is discarded; next request is 0x4000.
- rvalid and gnt in the same cycle at outstanding=MAX_OUTSTANDING, plus push and pop while full -> counters stay consistent; no overflow assertion fires.
- Address 0xFFFF_FFFF_FFFF_FFF8 -> next address 0x0 (wrap).
